// File: rtl/distance_smoother.sv
// Range-checked moving average of ultrasonic distance samples, with stale flagging after repeated rejects.
// Optional macro DISTANCE_SMOOTHER_SPIKE_REJECT_EN also rejects samples that jump too far from the current average.
module distance_smoother #(
    parameter int DATA_W      = 8,
    parameter int DEPTH_LOG2  = 2,
    parameter int MAX_VALID   = 200,
    parameter int HOLD_MAX    = 15,
    parameter int SPIKE_DELTA = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_distance,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_distance,
    output logic                  out_stale,
    output logic [DEPTH_LOG2:0]   fill_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = DATA_W + DEPTH_LOG2;
    localparam int REJ_W = $clog2(HOLD_MAX + 1);

    localparam logic [DATA_W-1:0]   MAX_V  = DATA_W'(MAX_VALID);
    localparam logic [DEPTH_LOG2:0] FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [REJ_W-1:0]    HOLD_V = REJ_W'(HOLD_MAX);

    if (MAX_VALID >= (1 << DATA_W) || HOLD_MAX < 1 || SPIKE_DELTA < 0) begin : g_param_check
        $error("distance_smoother: parameter out of range");
    end

    // S0: capture sample and range decision
    logic              s0_valid;
    logic              s0_in_range;
    logic [DATA_W-1:0] s0_distance;

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid    <= 1'b0;
            s0_in_range <= 1'b0;
            s0_distance <= '0;
        end else begin
            s0_valid    <= in_valid;
            s0_in_range <= (in_distance != '0) && (in_distance <= MAX_V);
            s0_distance <= in_distance;
        end
    end

    // S1: window state
    logic [DATA_W-1:0]     buf_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]      sum;
    logic [DEPTH_LOG2:0]   fill;
    logic [REJ_W-1:0]      rej_cnt;

    logic                  window_full;
    logic                  spike;
    logic                  accept;
    logic                  reject;
    logic                  flush;
    logic [SUM_W-1:0]      sum_next;
    logic [DEPTH_LOG2:0]   fill_next;
    logic [REJ_W-1:0]      rej_cnt_inc;
    logic [DATA_W-1:0]     res_calc;

    assign window_full = (fill == FULL);

`ifdef DISTANCE_SMOOTHER_SPIKE_REJECT_EN
    // Spike check sits in S1 so it always sees the average including the previous sample.
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] spike_diff;

    assign avg        = DATA_W'(sum >> DEPTH_LOG2);
    assign spike_diff = (s0_distance > avg) ? (s0_distance - avg) : (avg - s0_distance);
    assign spike      = window_full && (spike_diff > DATA_W'(SPIKE_DELTA));
`else
    assign spike = 1'b0;
`endif

    assign accept      = s0_valid && s0_in_range && !spike;
    assign reject      = s0_valid && !accept;
    assign rej_cnt_inc = rej_cnt + 1'b1;
    assign flush       = reject && (rej_cnt != HOLD_V) && (rej_cnt_inc == HOLD_V);

    always_comb begin
        sum_next  = sum + SUM_W'(s0_distance);
        fill_next = fill;
        if (window_full) begin
            sum_next = sum_next - SUM_W'(buf_mem[wr_ptr]);
        end else begin
            fill_next = fill + 1'b1;
        end
        res_calc = (fill_next == FULL) ? DATA_W'(sum_next >> DEPTH_LOG2) : s0_distance;
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            buf_mem[wr_ptr] <= s0_distance;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            sum     <= '0;
            fill    <= '0;
            rej_cnt <= '0;
        end else if (accept) begin
            wr_ptr  <= wr_ptr + 1'b1;
            sum     <= sum_next;
            fill    <= fill_next;
            rej_cnt <= '0;
        end else if (reject) begin
            if (rej_cnt != HOLD_V) begin
                rej_cnt <= rej_cnt_inc;
            end
            if (flush) begin
                wr_ptr <= '0;
                sum    <= '0;
                fill   <= '0;
            end
        end
    end

    logic              res_valid;
    logic [DATA_W-1:0] res_distance;
    logic              res_stale;

    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_distance <= '0;
            res_stale    <= 1'b0;
        end else begin
            res_valid    <= accept || flush;
            res_distance <= accept ? res_calc : '0;
            res_stale    <= !accept;
        end
    end

    // S2: output registers, held between pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_distance <= '0;
            out_stale    <= 1'b0;
        end else begin
            out_valid <= res_valid;
            if (res_valid) begin
                out_distance <= res_distance;
                out_stale    <= res_stale;
            end
        end
    end

    assign fill_count = fill;

endmodule

// File: tb/tb_distance_smoother.sv
// Directed bench for distance_smoother (HOLD_MAX = 4); follows DISTANCE_SMOOTHER_SPIKE_REJECT_EN for the spike case.
module tb_distance_smoother;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_distance;
    logic       out_valid;
    logic [7:0] out_distance;
    logic       out_stale;
    logic [2:0] fill_count;

    always #5 clock = ~clock;

    distance_smoother #(
        .DATA_W      (8),
        .DEPTH_LOG2  (2),
        .MAX_VALID   (200),
        .HOLD_MAX    (4),
        .SPIKE_DELTA (50)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_distance  (in_distance),
        .out_valid    (out_valid),
        .out_distance (out_distance),
        .out_stale    (out_stale),
        .fill_count   (fill_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse log, sampled mid-cycle
    int log_dist  [256];
    int log_stale [256];
    int log_fill  [256];
    int log_cyc   [256];
    int n_log = 0;

    always @(negedge clock) begin
        if (out_valid && n_log < 256) begin
            log_dist[n_log]  <= int'(out_distance);
            log_stale[n_log] <= int'(out_stale);
            log_fill[n_log]  <= int'(fill_count);
            log_cyc[n_log]   <= cyc;
            n_log            <= n_log + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, output int ec);
        @(negedge clock);
        in_valid    = 1'b1;
        in_distance = d[7:0];
        ec          = cyc + 3;
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ec [16];
        int dummy;
        int warm_exp [5];
        warm_exp = '{10, 20, 30, 25, 35};

        // Reset held 3 cycles with a live strobe
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_distance = 8'd50;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", int'(out_valid), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        base     = n_log;
        repeat (3) @(negedge clock);
        check("rst_pulses", n_log - base, 0);
        check("rst_dist", int'(out_distance), 0);
        check("rst_stale", int'(out_stale), 0);
        check("rst_fill", int'(fill_count), 0);

        // Warm-up pass-through, then averaging
        idle(2);
        base = n_log;
        for (int i = 0; i < 5; i++) send(10 * (i + 1), ec[i]);
        idle(5);
        check("warm_pulses", n_log - base, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("warm_dist%0d", i), log_dist[base + i], warm_exp[i]);
            check($sformatf("warm_lat%0d", i), log_cyc[base + i], ec[i]);
        end
        check("warm_fill", int'(fill_count), 4);

        // Truncation and pointer wrap
        do_reset();
        idle(2);
        base = n_log;
        send(1, dummy); send(1, dummy); send(1, dummy); send(2, dummy);
        for (int i = 0; i < 9; i++) send(2, dummy);
        idle(5);
        check("trunc_pulses", n_log - base, 13);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("trunc_dist%0d", i), log_dist[base + i], (i < 6) ? 1 : 2);
        end

        // Reject path and stale flush
        do_reset();
        for (int i = 0; i < 4; i++) send(30, dummy);
        idle(5);
        base = n_log;
        send(0, dummy); send(250, dummy); send(0, dummy);
        idle(5);
        check("rej_pulses", n_log - base, 0);
        check("rej_hold_dist", int'(out_distance), 30);
        check("rej_hold_stale", int'(out_stale), 0);
        check("rej_hold_fill", int'(fill_count), 4);
        send(201, dummy);
        idle(5);
        check("flush_pulses", n_log - base, 1);
        check("flush_dist", log_dist[base], 0);
        check("flush_stale", log_stale[base], 1);
        check("flush_fill", log_fill[base], 0);
        send(0, dummy);
        idle(5);
        check("stale_nopulse", n_log - base, 1);
        check("stale_hold", int'(out_stale), 1);
        send(60, dummy);
        idle(5);
        check("reacq_pulses", n_log - base, 2);
        check("reacq_dist", log_dist[base + 1], 60);
        check("reacq_stale", log_stale[base + 1], 0);
        check("reacq_fill", log_fill[base + 1], 1);

        // Spike
        do_reset();
        for (int i = 0; i < 4; i++) send(100, dummy);
        idle(5);
        base = n_log;
`ifdef DISTANCE_SMOOTHER_SPIKE_REJECT_EN
        for (int i = 0; i < 5; i++) send(180, dummy);
        idle(5);
        check("spike_pulses", n_log - base, 2);
        check("spike_flush_dist", log_dist[base], 0);
        check("spike_flush_stale", log_stale[base], 1);
        check("spike_pass_dist", log_dist[base + 1], 180);
        check("spike_pass_stale", log_stale[base + 1], 0);
`else
        send(180, dummy);
        idle(5);
        check("spike_pulses", n_log - base, 1);
        check("spike_avg", log_dist[base], 120);
        check("spike_fill", log_fill[base], 4);
`endif

        // Reset the cycle after a strobe
        do_reset();
        send(10, dummy); send(20, dummy);
        idle(5);
        base = n_log;
        send(70, dummy);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle(5);
        check("mid_rst_pulses", n_log - base, 0);
        check("mid_rst_fill", int'(fill_count), 0);
        check("mid_rst_dist", int'(out_distance), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
